// File: rtl/nbit_serial_addsub.sv
// Digit-serial WIDTH-bit adder/subtractor: DIGIT bits per clock, LSB first,
// with signed/unsigned overflow, optional saturation and start/busy/done handshake.
module nbit_serial_addsub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             signed_mode,
  input  logic             sat,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned DIGITS = WIDTH / DIGIT;
  localparam int unsigned SW     = DIGIT + 1;
  localparam int unsigned CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned XW     = WIDTH + DIGIT;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_part;
  logic             r_cy;
  logic [CW-1:0]    r_cnt;
  logic             r_sub;
  logic             r_signed;
  logic             r_sat;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_overflow;
  logic             r_zero;

  logic [DIGIT-1:0] w_a_sl;
  logic [DIGIT-1:0] w_b_sl;
  logic [SW-1:0]    w_sum;
  logic [WIDTH-1:0] w_part_next;
  logic [WIDTH-1:0] w_a_next;
  logic [WIDTH-1:0] w_b_next;
  logic             w_last;
  logic             w_cout;
  logic             w_cin_msb;
  logic             w_ovf;
  logic [WIDTH-1:0] w_sat_val;
  logic [WIDTH-1:0] w_res;

  // Digit slice adder, shifters and final flag/saturation logic
  always_comb begin
    w_a_sl      = r_a[DIGIT-1:0];
    w_b_sl      = r_b[DIGIT-1:0];
    w_sum       = SW'(w_a_sl) + SW'(w_b_sl) + SW'(r_cy);
    // sum slice enters at the top; after DIGITS shifts the result is aligned
    w_part_next = WIDTH'({w_sum[DIGIT-1:0], r_part} >> DIGIT);
    w_a_next    = WIDTH'({{DIGIT{1'b0}}, r_a} >> DIGIT);
    w_b_next    = WIDTH'({{DIGIT{1'b0}}, r_b} >> DIGIT);
    w_last      = (r_cnt == CW'(DIGITS - 1));
    w_cout      = w_sum[DIGIT];
    // on the last digit the slice MSBs are the operand MSBs
    w_cin_msb   = w_sum[DIGIT-1] ^ w_a_sl[DIGIT-1] ^ w_b_sl[DIGIT-1];
    w_ovf       = r_signed ? (w_cin_msb ^ w_cout) : (r_sub ? ~w_cout : w_cout);
    w_sat_val   = '0;
    if (r_signed) begin
      w_sat_val = w_a_sl[DIGIT-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                  : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      w_sat_val = r_sub ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
    end
    w_res = (r_sat && w_ovf) ? w_sat_val : w_part_next;
  end

  // Control FSM with datapath registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_part     <= '0;
      r_cy       <= 1'b0;
      r_cnt      <= '0;
      r_sub      <= 1'b0;
      r_signed   <= 1'b0;
      r_sat      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a      <= a;
            r_b      <= sub ? ~b : b;
            r_part   <= '0;
            r_cy     <= sub;
            r_cnt    <= '0;
            r_sub    <= sub;
            r_signed <= signed_mode;
            r_sat    <= sat;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_RUN: begin
          r_a    <= w_a_next;
          r_b    <= w_b_next;
          r_part <= w_part_next;
          r_cy   <= w_cout;
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) begin
            r_result   <= w_res;
            r_carry    <= w_cout;
            r_overflow <= w_ovf;
            r_zero     <= (w_res == '0);
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign carry    = r_carry;
  assign overflow = r_overflow;
  assign zero     = r_zero;

endmodule

// File: tb/tb_nbit_serial_addsub.sv
// Bench for nbit_serial_addsub: DIGIT=1, 4 and 8 builds side by side, an
// arithmetic reference model with per-cycle compare, plus literal vectors.
module tb_nbit_serial_addsub;

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic        m;
    logic        t;
    logic [10:0] e;   // {carry, overflow, zero, result}
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] start = 3'b000;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       sub = 1'b0;
  logic       sm = 1'b0;
  logic       sat = 1'b0;

  logic [2:0] busy, done, carry, ovf, zero;
  logic [7:0] res [3];

  int checks = 0;
  int errors = 0;

  int          m_cnt  [3] = '{0, 0, 0};
  logic        m_done [3] = '{1'b0, 1'b0, 1'b0};
  logic [10:0] m_out  [3] = '{11'h0, 11'h0, 11'h0};
  logic [10:0] m_pend [3] = '{11'h0, 11'h0, 11'h0};

  vec_t vecs [11];

  always #5 clk = ~clk;

  nbit_serial_addsub #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start[0]), .a(a), .b(b), .sub(sub),
    .signed_mode(sm), .sat(sat), .busy(busy[0]), .done(done[0]),
    .result(res[0]), .carry(carry[0]), .overflow(ovf[0]), .zero(zero[0]));

  nbit_serial_addsub #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start[1]), .a(a), .b(b), .sub(sub),
    .signed_mode(sm), .sat(sat), .busy(busy[1]), .done(done[1]),
    .result(res[1]), .carry(carry[1]), .overflow(ovf[1]), .zero(zero[1]));

  nbit_serial_addsub #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .start(start[2]), .a(a), .b(b), .sub(sub),
    .signed_mode(sm), .sat(sat), .busy(busy[2]), .done(done[2]),
    .result(res[2]), .carry(carry[2]), .overflow(ovf[2]), .zero(zero[2]));

  function automatic int lat_of(input int k);
    return (k == 0) ? 8 : ((k == 1) ? 2 : 1);
  endfunction

  // Reference arithmetic: {carry, overflow, zero, result}
  function automatic logic [10:0] model_op(input logic [7:0] ia, input logic [7:0] ib,
                                           input logic is, input logic ism, input logic ist);
    int ua, ub, ur, sa, sb, sr;
    logic c, o;
    logic [7:0] r;
    ua = int'(ia);
    ub = int'(ib);
    sa = int'($signed(ia));
    sb = int'($signed(ib));
    ur = is ? ua - ub : ua + ub;
    sr = is ? sa - sb : sa + sb;
    c  = is ? (ua >= ub) : (ur > 255);
    r  = 8'(ur);
    o  = ism ? (sr > 127 || sr < -128) : (is ? !c : c);
    if (ist && o) r = ism ? (ia[7] ? 8'h80 : 8'h7F) : (is ? 8'h00 : 8'hFF);
    return {c, o, (r == 8'h00), r};
  endfunction

  // Cycle-level behaviour: busy for lat edges, then a one-cycle done
  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_cnt[k]  <= 0;
        m_done[k] <= 1'b0;
        m_out[k]  <= '0;
      end else if (m_cnt[k] > 0) begin
        m_cnt[k]  <= m_cnt[k] - 1;
        m_done[k] <= (m_cnt[k] == 1);
        if (m_cnt[k] == 1) m_out[k] <= m_pend[k];
      end else begin
        m_done[k] <= 1'b0;
        if (start[k]) begin
          m_cnt[k]  <= lat_of(k);
          m_pend[k] <= model_op(a, b, sub, sm, sat);
        end
      end
    end
  end

  // Every-cycle compare of all outputs against the model
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic [12:0] exp_v, act_v;
      exp_v = {(m_cnt[k] > 0), m_done[k], m_out[k]};
      act_v = {busy[k], done[k], carry[k], ovf[k], zero[k], res[k]};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_cmp inst=%0d t=%0t got=%h want=%h", k, $time, act_v, exp_v);
      end
    end
  end

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic wait_done(input int k, output int n);
    n = 0;
    while (done[k] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done[k] !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout inst=%0d got=0 want=1", k);
    end
  endtask

  task automatic issue(input int k, input vec_t v);
    @(negedge clk);
    a = v.a; b = v.b; sub = v.s; sm = v.m; sat = v.t;
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  task automatic check_out(input int k, input logic [10:0] e);
    check_val($sformatf("result_i%0d", k), {24'h0, res[k]}, {24'h0, e[7:0]});
    check_val($sformatf("flags_i%0d", k), {29'h0, carry[k], ovf[k], zero[k]}, {29'h0, e[10:8]});
  endtask

  task automatic run_op(input int k, input vec_t v);
    int n;
    issue(k, v);
    wait_done(k, n);
    check_val($sformatf("latency_i%0d", k), 32'(n), 32'(lat_of(k)));
    check_out(k, v.e);
  endtask

  initial begin
    int n;
    vec_t v;
    vecs[0]  = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, {1'b0, 1'b0, 1'b1, 8'h00}};
    vecs[1]  = '{8'h42, 8'hC0, 1'b0, 1'b0, 1'b0, {1'b1, 1'b1, 1'b0, 8'h02}};
    vecs[2]  = '{8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, {1'b1, 1'b1, 1'b0, 8'hFE}};
    vecs[3]  = '{8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, {1'b1, 1'b1, 1'b0, 8'hFF}};
    vecs[4]  = '{8'h91, 8'h64, 1'b1, 1'b0, 1'b0, {1'b1, 1'b0, 1'b0, 8'h2D}};
    vecs[5]  = '{8'h32, 8'h64, 1'b1, 1'b0, 1'b0, {1'b0, 1'b1, 1'b0, 8'hCE}};
    vecs[6]  = '{8'h32, 8'h64, 1'b1, 1'b0, 1'b1, {1'b0, 1'b1, 1'b1, 8'h00}};
    vecs[7]  = '{8'h64, 8'h64, 1'b0, 1'b1, 1'b0, {1'b0, 1'b1, 1'b0, 8'hC8}};
    vecs[8]  = '{8'h64, 8'h64, 1'b0, 1'b1, 1'b1, {1'b0, 1'b1, 1'b0, 8'h7F}};
    vecs[9]  = '{8'h9C, 8'h64, 1'b1, 1'b1, 1'b1, {1'b1, 1'b1, 1'b0, 8'h80}};
    vecs[10] = '{8'h32, 8'hEC, 1'b0, 1'b1, 1'b0, {1'b1, 1'b0, 1'b0, 8'h1E}};

    // reset state
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("rst_ctl_i%0d", k), {30'h0, busy[k], done[k]}, 32'h0);
      check_out(k, 11'h000);
    end
    rst = 1'b0;

    // directed vectors on every digit width
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 11; i++)
        run_op(k, vecs[i]);

    // start during RUN is ignored; original result at original latency
    issue(0, vecs[1]);
    repeat (3) @(negedge clk);
    a = 8'h01; b = 8'h01; sub = 1'b1; sm = 1'b1; sat = 1'b1;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, n);
    check_val("ignored_start_latency", 32'(n + 4), 32'd8);
    check_out(0, vecs[1].e);

    // start in the DONE cycle goes straight back to RUN
    issue(0, vecs[2]);
    wait_done(0, n);
    v = vecs[4];
    a = v.a; b = v.b; sub = v.s; sm = v.m; sat = v.t;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    check_val("b2b_busy_done", {30'h0, busy[0], done[0]}, 32'h2);
    check_val("b2b_held_result", {24'h0, res[0]}, 32'h0000_00FE);
    wait_done(0, n);
    check_val("b2b_latency", 32'(n), 32'd8);
    check_out(0, vecs[4].e);

    // asynchronous reset three edges into RUN
    issue(0, vecs[1]);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("async_rst_ctl_i%0d", k), {30'h0, busy[k], done[k]}, 32'h0);
      check_out(k, 11'h000);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_val("no_done_after_rst", {31'h0, done[0]}, 32'h0);
    run_op(0, vecs[4]);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
